float_minmax: RTL



---
 rtl/float_pkg.sv | 48 ++++
 rtl/float_order_cmp.sv | 41 ++++
 rtl/float_minmax.sv | 139 +++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Shared helpers for the float component library.
// Functions work on a zero-extended MaxW-bit word so one definition serves every
// EXP_W/MAN_W instantiation; callers pass the field widths explicitly.
package float_pkg;

  localparam int unsigned MaxW = 128;
  typedef logic [MaxW-1:0] word_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Total word width: sign + exponent + mantissa.
  function automatic int unsigned w(int unsigned exp_w, int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic word_t field_mask(int unsigned n);
    word_t m;
    m = '0;
    for (int unsigned i = 0; i < MaxW; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic exp_all_ones(word_t x, int unsigned exp_w, int unsigned man_w);
    return ((x >> man_w) & field_mask(exp_w)) == field_mask(exp_w);
  endfunction

  function automatic logic is_nan(word_t x, int unsigned exp_w, int unsigned man_w);
    return exp_all_ones(x, exp_w, man_w) && ((x & field_mask(man_w)) != '0);
  endfunction

  // Signalling NaN: NaN with the mantissa MSB (quiet bit) clear.
  function automatic logic is_snan(word_t x, int unsigned exp_w, int unsigned man_w);
    return is_nan(x, exp_w, man_w) && !x[man_w-1];
  endfunction

  function automatic logic is_zero(word_t x, int unsigned exp_w, int unsigned man_w);
    return (x & field_mask(exp_w + man_w)) == '0;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic word_t canon_qnan(int unsigned exp_w, int unsigned man_w);
    return (field_mask(exp_w) << man_w) | (word_t'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/float_order_cmp.sv
// Combinational sign-magnitude total-order comparator.
// Ports:
//   a_i, b_i    operands (sign, exponent, mantissa)
//   a_lt_b_o    a strictly below b; -0 orders below +0, NaNs are not special-cased
//   a_eq_b_o    identical encodings
module float_order_cmp
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = float_pkg::w(EXP_W, MAN_W)
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         a_lt_b_o,
  output logic         a_eq_b_o
);

  logic         sign_a, sign_b;
  logic [W-2:0] mag_a, mag_b;

  assign sign_a   = a_i[W-1];
  assign sign_b   = b_i[W-1];
  assign mag_a    = a_i[W-2:0];
  assign mag_b    = b_i[W-2:0];
  assign a_eq_b_o = (a_i == b_i);

  always_comb begin
    a_lt_b_o = 1'b0;
    if (sign_a != sign_b) begin
      // Any negative encoding (including -0) is below any positive one.
      a_lt_b_o = sign_a;
    end else if (!sign_a) begin
      a_lt_b_o = (mag_a < mag_b);
    end else begin
      // Both negative: larger magnitude is the smaller value.
      a_lt_b_o = (mag_a > mag_b);
    end
  end

endmodule

// File: rtl/float_minmax.sv
// Two-stage pipelined floating-point min/max with valid/ready handshake.
// S1 registers operands, mode, NaN classification and the order compare;
// S2 registers the selected result.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_a, in_b, in_mode    operands and mode (0 = min, 1 = max)
//   in_valid, in_ready     input handshake; in_ready = !out_valid || out_ready
//   out_z, out_sel         result and source (0 = a or canonical NaN, 1 = b)
//   out_valid, out_ready   output handshake
//   out_invalid            only with FLOAT_MINMAX_FLAGS_EN: an operand was a signalling NaN
module float_minmax
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = float_pkg::w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_mode,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_z,
  output logic         out_sel,
`ifdef FLOAT_MINMAX_FLAGS_EN
  output logic         out_invalid,
`endif
  output logic         out_valid,
  input  logic         out_ready
);

  localparam word_t        QNanFull = canon_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNan     = QNanFull[W-1:0];

  // Whole pipeline advances together; S2 empty or being drained frees every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic cmp_lt, cmp_eq;

  float_order_cmp #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_cmp (
    .a_i     (in_a),
    .b_i     (in_b),
    .a_lt_b_o(cmp_lt),
    .a_eq_b_o(cmp_eq)
  );

  logic         in_a_nan, in_b_nan;
  assign in_a_nan = is_nan(word_t'(in_a), EXP_W, MAN_W);
  assign in_b_nan = is_nan(word_t'(in_b), EXP_W, MAN_W);

  // S1
  logic         v1_q;
  logic [W-1:0] a1_q, b1_q;
  logic         mode1_q, a_nan1_q, b_nan1_q, lt1_q, eq1_q;
`ifdef FLOAT_MINMAX_FLAGS_EN
  logic         inv1_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      mode1_q  <= MODE_MIN;
      a_nan1_q <= 1'b0;
      b_nan1_q <= 1'b0;
      lt1_q    <= 1'b0;
      eq1_q    <= 1'b0;
`ifdef FLOAT_MINMAX_FLAGS_EN
      inv1_q   <= 1'b0;
`endif
    end else if (adv) begin
      v1_q     <= in_valid;
      a1_q     <= in_a;
      b1_q     <= in_b;
      mode1_q  <= in_mode;
      a_nan1_q <= in_a_nan;
      b_nan1_q <= in_b_nan;
      lt1_q    <= cmp_lt;
      eq1_q    <= cmp_eq;
`ifdef FLOAT_MINMAX_FLAGS_EN
      inv1_q   <= is_snan(word_t'(in_a), EXP_W, MAN_W) || is_snan(word_t'(in_b), EXP_W, MAN_W);
`endif
    end
  end

  // Result selection from S1 state.
  logic [W-1:0] z_d;
  logic         sel_d;

  always_comb begin
    z_d   = a1_q;
    sel_d = 1'b0;
    if (a_nan1_q && b_nan1_q) begin
      z_d   = QNan;
      sel_d = 1'b0;
    end else if (a_nan1_q) begin
      z_d   = b1_q;
      sel_d = 1'b1;
    end else if (b_nan1_q) begin
      z_d   = a1_q;
      sel_d = 1'b0;
    end else begin
      // Equal encodings keep a: neither lt nor b-below-a holds.
      if (mode1_q == MODE_MAX) sel_d = lt1_q;
      else                     sel_d = !lt1_q && !eq1_q;
      z_d = sel_d ? b1_q : a1_q;
    end
  end

  // S2
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_z       <= '0;
      out_sel     <= 1'b0;
`ifdef FLOAT_MINMAX_FLAGS_EN
      out_invalid <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= v1_q;
      if (v1_q) begin
        out_z       <= z_d;
        out_sel     <= sel_d;
`ifdef FLOAT_MINMAX_FLAGS_EN
        out_invalid <= inv1_q;
`endif
      end
    end
  end

endmodule
